// File: rtl/pin_auth_pkg.sv
// Shared types and constants for the PIN authentication engine.
// Default PINs are stored as four BCD digits, so "1234" is 16'h1234.
package pin_auth_pkg;

  typedef enum logic [1:0] {
    OP_AUTH       = 2'd0,
    OP_CHANGE_PIN = 2'd1,
    OP_UNLOCK     = 2'd2,
    OP_RSVD       = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_AUTH_OK     = 3'd0,
    ST_NOT_FOUND   = 3'd1,
    ST_BAD_PIN     = 3'd2,
    ST_LOCKED      = 3'd3,
    ST_PIN_CHANGED = 3'd4,
    ST_PIN_SAME    = 3'd5,
    ST_UNLOCKED    = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_CHECK  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Fail counter width; covers MAX_TRIES up to 7.
  localparam int CNT_W = 3;

  localparam logic [15:0] DEFAULT_PINS [16] = '{
    16'h1234, 16'h2345, 16'h3456, 16'h4567,
    16'h5678, 16'h6789, 16'h7890, 16'h8901,
    16'h9012, 16'h7123, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/pin_auth_if.sv
// Request/response handshake bundle between a client and pin_auth_engine.
interface pin_auth_if
  import pin_auth_pkg::*;
#(
  parameter int ACC_W = 4,
  parameter int PIN_W = 16,
  parameter int IDX_W = 4
);
  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [ACC_W-1:0] req_acc_num;
  logic [PIN_W-1:0] req_pin;
  logic [PIN_W-1:0] req_new_pin;
  logic             rsp_valid;
  logic             rsp_ready;
  status_e          rsp_status;
  logic [IDX_W-1:0] rsp_acc_index;

  modport master (
    output req_valid, req_op, req_acc_num, req_pin, req_new_pin, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_acc_index
  );

  modport slave (
    input  req_valid, req_op, req_acc_num, req_pin, req_new_pin, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_acc_index
  );
endinterface

// File: rtl/pin_auth_db.sv
// PIN table plus per-account fail counters.
// Counters and lock detection exist only when AUTH_LOCKOUT_EN is defined.
module pin_auth_db
  import pin_auth_pkg::*;
#(
  parameter int NUM_ACCTS = 10,
  parameter int PIN_W     = 16,
  parameter int MAX_TRIES = 3,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PIN_W-1:0] rd_pin,
  output logic             rd_locked,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             we,
  input  logic [PIN_W-1:0] wr_pin,
  input  logic             cnt_clr,
  input  logic             cnt_inc
);

  logic [PIN_W-1:0] pin_q [NUM_ACCTS];

  // PIN storage: reset restores the factory PINs, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCTS; i++) pin_q[i] <= PIN_W'(DEFAULT_PINS[i]);
    end else if (we) begin
      pin_q[wr_idx] <= wr_pin;
    end
  end

  assign rd_pin = pin_q[rd_idx];

`ifdef AUTH_LOCKOUT_EN
  logic [CNT_W-1:0] fail_q [NUM_ACCTS];

  // Consecutive-failure counters; clear wins over increment, saturate at MAX_TRIES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCTS; i++) fail_q[i] <= '0;
    end else if (cnt_clr) begin
      fail_q[wr_idx] <= '0;
    end else if (cnt_inc && (fail_q[wr_idx] != CNT_W'(MAX_TRIES))) begin
      fail_q[wr_idx] <= fail_q[wr_idx] + CNT_W'(1);
    end
  end

  assign rd_locked = (fail_q[rd_idx] == CNT_W'(MAX_TRIES));
`else
  localparam int unused_max_tries = MAX_TRIES;
  logic unused_cnt_ctrl;
  assign unused_cnt_ctrl = cnt_clr ^ cnt_inc;
  assign rd_locked = 1'b0;
`endif

endmodule

// File: rtl/pin_auth_engine.sv
// PIN authentication engine: linear account search, PIN check/change,
// lockout after repeated failures (only with AUTH_LOCKOUT_EN defined).
// Account i is numbered i+1, so account number 0 never matches.
module pin_auth_engine
  import pin_auth_pkg::*;
#(
  parameter int NUM_ACCTS = 10,
  parameter int ACC_W     = 4,
  parameter int PIN_W     = 16,
  parameter int MAX_TRIES = 3
) (
  input logic      clk,
  input logic      rst_n,
  pin_auth_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_ACCTS);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q;
  logic [PIN_W-1:0] new_pin_q;
  logic [IDX_W-1:0] idx_q;
  status_e          status_q, status_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;

  logic [PIN_W-1:0] rd_pin;
  logic             locked;
  logic             db_we, cnt_clr, cnt_inc;
  logic             acc_match, last_entry, accept;

  assign accept     = (state_q == S_IDLE) && bus.req_valid;
  assign acc_match  = ({1'b0, acc_q} == ((ACC_W+1)'(idx_q) + (ACC_W+1)'(1)));
  assign last_entry = (idx_q == IDX_W'(NUM_ACCTS - 1));

  pin_auth_db #(
    .NUM_ACCTS (NUM_ACCTS),
    .PIN_W     (PIN_W),
    .MAX_TRIES (MAX_TRIES),
    .IDX_W     (IDX_W)
  ) u_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx_q),
    .rd_pin    (rd_pin),
    .rd_locked (locked),
    .wr_idx    (idx_q),
    .we        (db_we),
    .wr_pin    (new_pin_q),
    .cnt_clr   (cnt_clr),
    .cnt_inc   (cnt_inc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, response status and table/counter updates.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    rsp_idx_d = rsp_idx_q;
    db_we     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (acc_match) begin
          state_d = S_CHECK;
        end else if (last_entry) begin
          state_d   = S_RESP;
          status_d  = ST_NOT_FOUND;
          rsp_idx_d = '0;
        end
      end
      S_CHECK: begin
        state_d   = S_RESP;
        rsp_idx_d = idx_q;
        if (op_q == OP_UNLOCK) begin
          status_d = ST_UNLOCKED;
          cnt_clr  = 1'b1;
        end else if (locked) begin
          status_d = ST_LOCKED;
        end else if (pin_q != rd_pin) begin
          status_d = ST_BAD_PIN;
          cnt_inc  = 1'b1;
        end else if (op_q == OP_CHANGE_PIN) begin
          if (new_pin_q == rd_pin) begin
            status_d = ST_PIN_SAME;
          end else begin
            status_d = ST_PIN_CHANGED;
            db_we    = 1'b1;
            cnt_clr  = 1'b1;
          end
        end else begin
          status_d = ST_AUTH_OK;
          cnt_clr  = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Search index and response registers (held stable through RESP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      status_q  <= ST_AUTH_OK;
      rsp_idx_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= '0;
      end else if ((state_q == S_SEARCH) && !acc_match && !last_entry) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      status_q  <= status_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

  // Request fields captured on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= bus.req_op;
      acc_q     <= bus.req_acc_num;
      pin_q     <= bus.req_pin;
      new_pin_q <= bus.req_new_pin;
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.rsp_valid     = (state_q == S_RESP);
  assign bus.rsp_status    = status_q;
  assign bus.rsp_acc_index = rsp_idx_q;

endmodule

// File: tb/tb_pin_auth_engine.sv
// Testbench for pin_auth_engine: directed scenarios plus randomized traffic
// against a behavioural account model. Honours AUTH_LOCKOUT_EN like the design.
module tb_pin_auth_engine;
  import pin_auth_pkg::*;

  localparam int N         = 10;
  localparam int ACC_W     = 4;
  localparam int PIN_W     = 16;
  localparam int MAX_TRIES = 3;
  localparam int IDX_W     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pin_auth_if #(.ACC_W(ACC_W), .PIN_W(PIN_W), .IDX_W(IDX_W)) bus ();

  pin_auth_engine #(
    .NUM_ACCTS (N),
    .ACC_W     (ACC_W),
    .PIN_W     (PIN_W),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Account model: PIN per account and consecutive failure count.
  logic [15:0] m_pin [16];
  int          m_fail [16];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pin[i]  = DEFAULT_PINS[i];
      m_fail[i] = 0;
    end
  endfunction

  task automatic model(input op_e op, input int acc, input logic [15:0] pin,
                       input logic [15:0] newp, output status_e st,
                       output int idx, output int lat);
    bit lk;
    if (acc < 1 || acc > N) begin
      st = ST_NOT_FOUND; idx = 0; lat = N;
      return;
    end
    idx = acc - 1;
    lat = idx + 2;
`ifdef AUTH_LOCKOUT_EN
    lk = (m_fail[idx] >= MAX_TRIES);
`else
    lk = 1'b0;
`endif
    if (op == OP_UNLOCK) begin
      st = ST_UNLOCKED;
      m_fail[idx] = 0;
    end else if (lk) begin
      st = ST_LOCKED;
    end else if (pin != m_pin[idx]) begin
      st = ST_BAD_PIN;
      if (m_fail[idx] < MAX_TRIES) m_fail[idx]++;
    end else if (op == OP_CHANGE_PIN && newp == m_pin[idx]) begin
      st = ST_PIN_SAME;
    end else if (op == OP_CHANGE_PIN) begin
      st = ST_PIN_CHANGED;
      m_pin[idx] = newp;
      m_fail[idx] = 0;
    end else begin
      st = ST_AUTH_OK;
      m_fail[idx] = 0;
    end
  endtask

  task automatic do_txn(input op_e op, input int acc, input logic [15:0] pin,
                        input logic [15:0] newp, input int hold, output status_e got);
    status_e est;
    int eidx, elat, cnt;
    logic [2:0] st0;
    logic [IDX_W-1:0] ix0;
    model(op, acc, pin, newp, est, eidx, elat);
    @(negedge clk);
    bus.req_op      = op;
    bus.req_acc_num = ACC_W'(acc);
    bus.req_pin     = pin;
    bus.req_new_pin = newp;
    bus.req_valid   = 1'b1;
    chk("req_ready_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("req_ready_busy", bus.req_ready, 0);
    cnt = 0;
    while (!bus.rsp_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, elat);
    st0 = bus.rsp_status;
    ix0 = bus.rsp_acc_index;
    got = status_e'(st0);
    chk("status", st0, est);
    chk("acc_index", ix0, eidx);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_status", bus.rsp_status, st0);
      chk("hold_index", bus.rsp_acc_index, ix0);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", bus.rsp_valid, 0);
    chk("req_ready_after_hs", bus.req_ready, 1);
  endtask

  initial begin
    status_e s;
    int acc, opi;
    logic [15:0] pin, newp;

    bus.req_valid   = 1'b0;
    bus.req_op      = OP_AUTH;
    bus.req_acc_num = '0;
    bus.req_pin     = '0;
    bus.req_new_pin = '0;
    bus.rsp_ready   = 1'b0;
    model_reset();

    #12;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_status", bus.rsp_status, 0);
    chk("rst_rsp_index", bus.rsp_acc_index, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 1);

    // Basic authentication and not-found cases.
    do_txn(OP_AUTH, 1, 16'h1234, 16'h0, 0, s);
    chk("auth_acc1", s, ST_AUTH_OK);
    do_txn(OP_AUTH, 12, 16'h1234, 16'h0, 0, s);
    chk("acc12_nf", s, ST_NOT_FOUND);
    do_txn(OP_AUTH, 0, 16'h1234, 16'h0, 0, s);
    chk("acc0_nf", s, ST_NOT_FOUND);
    do_txn(OP_AUTH, 10, 16'h7123, 16'h0, 0, s);
    chk("auth_acc10", s, ST_AUTH_OK);
    do_txn(OP_RSVD, 4, 16'h4567, 16'h0, 0, s);
    chk("rsvd_as_auth", s, ST_AUTH_OK);

`ifdef AUTH_LOCKOUT_EN
    // Lockout and unlock.
    for (int i = 0; i < 3; i++) begin
      do_txn(OP_AUTH, 3, 16'h0000, 16'h0, 0, s);
      chk("lock_bad", s, ST_BAD_PIN);
    end
    do_txn(OP_AUTH, 3, 16'h3456, 16'h0, 0, s);
    chk("lock_locked", s, ST_LOCKED);
    do_txn(OP_CHANGE_PIN, 3, 16'h3456, 16'h1111, 0, s);
    chk("lock_change_locked", s, ST_LOCKED);
    do_txn(OP_UNLOCK, 3, 16'h0000, 16'h0, 0, s);
    chk("lock_unlock", s, ST_UNLOCKED);
    do_txn(OP_AUTH, 3, 16'h3456, 16'h0, 0, s);
    chk("lock_ok", s, ST_AUTH_OK);
`else
    // Without lockout, repeated failures never lock.
    for (int i = 0; i < 5; i++) begin
      do_txn(OP_AUTH, 5, 16'h0000, 16'h0, 0, s);
      chk("nolock_bad", s, ST_BAD_PIN);
    end
    do_txn(OP_AUTH, 5, 16'h5678, 16'h0, 0, s);
    chk("nolock_ok", s, ST_AUTH_OK);
    do_txn(OP_UNLOCK, 5, 16'h0000, 16'h0, 0, s);
    chk("nolock_unlock", s, ST_UNLOCKED);
`endif

    // PIN change sequence, with a held-off response.
    do_txn(OP_CHANGE_PIN, 2, 16'h2345, 16'h2345, 0, s);
    chk("chg_same", s, ST_PIN_SAME);
    do_txn(OP_CHANGE_PIN, 2, 16'h2345, 16'h1111, 5, s);
    chk("chg_changed", s, ST_PIN_CHANGED);
    do_txn(OP_AUTH, 2, 16'h2345, 16'h0, 0, s);
    chk("chg_old_bad", s, ST_BAD_PIN);
    do_txn(OP_AUTH, 2, 16'h1111, 16'h0, 0, s);
    chk("chg_new_ok", s, ST_AUTH_OK);

    // Reset during SEARCH of a pending change aborts it and restores defaults.
    @(negedge clk);
    bus.req_op      = OP_CHANGE_PIN;
    bus.req_acc_num = ACC_W'(2);
    bus.req_pin     = 16'h1111;
    bus.req_new_pin = 16'h4444;
    bus.req_valid   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_status", bus.rsp_status, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", bus.rsp_valid, 0);
    end
    chk("midrst_req_ready", bus.req_ready, 1);
    do_txn(OP_AUTH, 2, 16'h2345, 16'h0, 0, s);
    chk("midrst_auth", s, ST_AUTH_OK);

    // Randomized traffic against the model.
    for (int t = 0; t < 120; t++) begin
      opi = $urandom_range(0, 3);
      if ($urandom_range(0, 4) != 0) acc = $urandom_range(1, N);
      else                           acc = $urandom_range(0, 15);
      if (acc >= 1 && acc <= N && $urandom_range(0, 1) == 1) pin = m_pin[acc-1];
      else if ($urandom_range(0, 1) == 1)                    pin = 16'h0000;
      else                                                   pin = 16'($urandom);
      if ($urandom_range(0, 3) == 0) newp = pin;
      else                           newp = 16'($urandom);
      do_txn(op_e'(opi), acc, pin, newp, $urandom_range(0, 3), s);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
